onehot_scan_encoder: RTL and testbench



---
 rtl/onehot_scan_encoder.sv | 117 +++++++++++
 tb/tb_onehot_scan_encoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder
// Sequential bit-scan encoder: takes a WIDTH-bit request vector and emits,
// one beat per out_valid/out_ready handshake, the binary index of every set
// bit, lowest index first. An all-zero vector yields a single beat flagged
// with out_none.
//
// Ports:
//   clk        single clock, rising-edge
//   reset_n    asynchronous active-low reset
//   in_valid   in_vec is valid
//   in_ready   block can accept a vector (IDLE and out of reset)
//   in_vec     request vector, bit i set = index i requested
//   out_valid  out_addr/out_last/out_none are valid
//   out_ready  consumer takes the current beat
//   out_addr   index of the lowest pending set bit
//   out_last   current beat is the final beat of this vector
//   out_none   vector was all-zero; out_addr is 0 and meaningless
module onehot_scan_encoder #(
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_addr,
  output logic             out_last,
  output logic             out_none
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  // Goes high on the first edge after reset release; keeps in_ready low
  // while reset is asserted without a combinational path from reset_n.
  logic             alive_q, alive_d;
  logic             single;

  // Fixed priority: the loop runs high-to-low so the lowest set bit wins.
  function automatic logic [AW-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  // Exactly one bit set <=> clearing the lowest set bit leaves nothing.
  assign single = (pending_q != '0) &&
                  ((pending_q & (pending_q - WIDTH'(1))) == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    alive_d   = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_addr  = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = alive_q;
        if (in_valid && alive_q) begin
          if (in_vec != '0) begin
            pending_d = in_vec;
            state_d   = SCAN;
          end else begin
            state_d = ZERO;
          end
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_addr  = lowest_idx(pending_q);
        out_last  = single;
        if (out_ready) begin
          // Drop the lowest set bit, i.e. the one just emitted.
          pending_d = pending_q & (pending_q - WIDTH'(1));
          if (single) state_d = IDLE;
        end
      end
      ZERO: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_none  = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      alive_q   <= alive_d;
    end
  end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Self-checking bench for onehot_scan_encoder: table of vectors with
// hand-computed beat sequences, plus hand-written reset, backpressure and
// mid-scan reset sequences.
module tb_onehot_scan_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_addr;
  logic       out_last;
  logic       out_none;

  int n_pass = 0;
  int n_total = 0;

  onehot_scan_encoder #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_last (out_last),
    .out_none (out_none)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vec;
    int         nbeats;
    logic [2:0] addrs [4];
    logic       none;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(logic [7:0] v, int n, logic [2:0] a0, logic [2:0] a1,
                              logic [2:0] a2, logic [2:0] a3, logic z);
    vec_t r;
    r.vec = v; r.nbeats = n; r.none = z;
    r.addrs[0] = a0; r.addrs[1] = a1; r.addrs[2] = a2; r.addrs[3] = a3;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector (expects in_ready=1 now), then consume its beats with
  // out_ready held high, checking every beat and the return to IDLE.
  task automatic run_vec(vec_t t);
    in_valid = 1'b1;
    in_vec   = t.vec;
    out_ready = 1'b1;
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_vec   = ~t.vec;  // must not disturb the scan in progress
    for (int k = 0; k < t.nbeats; k++) begin
      chk("beat_valid", out_valid, 1);
      chk("beat_addr", out_addr, t.addrs[k]);
      chk("beat_last", out_last, (k == t.nbeats - 1) ? 1 : 0);
      chk("beat_none", out_none, t.none);
      chk("beat_in_ready", in_ready, 0);
      tick();
    end
    chk("after_valid", out_valid, 0);
    chk("after_ready", in_ready, 1);
  endtask

  initial begin
    tbl[0] = mk(8'b0000_0100, 1, 3'd2, 3'd0, 3'd0, 3'd0, 1'b0);
    tbl[1] = mk(8'b1010_0001, 3, 3'd0, 3'd5, 3'd7, 3'd0, 1'b0);
    tbl[2] = mk(8'h00,        1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    tbl[3] = mk(8'h80,        1, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0);
    tbl[4] = mk(8'b0101_0110, 4, 3'd1, 3'd2, 3'd4, 3'd6, 1'b0);
    tbl[5] = mk(8'h01,        1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);

    // Reset held with an active request present
    reset_n = 1'b0; in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
    #2;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_addr", out_addr, 0);
    end
    reset_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    in_valid = 1'b0;

    // Table vectors, back-to-back (zero vector followed by 8'h80)
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Full vector with toggling backpressure
    in_valid = 1'b1; in_vec = 8'hFF;
    tick();
    in_valid = 1'b0; in_vec = 8'h00;
    for (int k = 0; k < 8; k++) begin
      out_ready = 1'b0;
      chk("bp_valid", out_valid, 1);
      chk("bp_addr", out_addr, k);
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_addr", out_addr, k);
      chk("bp_hold_last", out_last, (k == 7) ? 1 : 0);
      out_ready = 1'b1;
      tick();
    end
    chk("bp_done_valid", out_valid, 0);
    chk("bp_done_ready", in_ready, 1);

    // Reset mid-scan after addr 4 is accepted
    in_valid = 1'b1; in_vec = 8'b1111_0000;
    tick();
    in_valid = 1'b0;
    chk("mid_addr4", out_addr, 4);
    tick();
    chk("mid_addr5_shown", out_addr, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_async_valid", out_valid, 0);
    chk("mid_async_ready", in_ready, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_post_ready", in_ready, 1);
    for (int c = 0; c < 3; c++) begin
      chk("mid_no_beats", out_valid, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
